// File: rtl/state_hist_pkg.sv
// Shared sizing defaults, read-FSM state encoding and entry layout for the
// state history buffer.
package state_hist_pkg;

  localparam int STATE_W_D = 8;
  localparam int DEPTH_D   = 16;
  localparam int TS_W_D    = 16;
  localparam int AW        = $clog2(DEPTH_D);
  localparam int CNT_W     = AW + 1;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_LOOK,
    RD_DONE
  } rd_state_t;

  typedef struct packed {
    logic [STATE_W_D-1:0] state;
    logic [TS_W_D-1:0]    ts;
  } entry_t;

endpackage

// File: rtl/state_hist_ram.sv
// Simple dual-port history store: one write port, one registered read port.
// Read and write to the same slot on the same edge return the old contents.
module state_hist_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              iClk,
  input  logic              iWrEn,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [WIDTH-1:0]  iWrData,
  input  logic              iRdEn,
  input  logic [ADDR_W-1:0] iRdAddr,
  output logic [WIDTH-1:0]  oRdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge iClk) begin
    if (iWrEn) begin
      mem[iWrAddr] <= iWrData;
    end
    if (iRdEn) begin
      oRdData <= mem[iRdAddr];
    end
  end

endmodule

// File: rtl/state_history_buffer.sv
// Logs every change of the logger's current state into a ring buffer and serves
// age-indexed reads. Define STATE_HIST_TS_EN to store per-entry dwell-tick counts.
module state_history_buffer
  import state_hist_pkg::*;
#(
  parameter int STATE_W = STATE_W_D,
  parameter int DEPTH   = DEPTH_D,
  parameter int TS_W    = TS_W_D,
  localparam int ADDR_W   = $clog2(DEPTH),
  localparam int CNT_BITS = ADDR_W + 1
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iClear,
  input  logic [STATE_W-1:0]  iCurState,
  input  logic                iFreeze,
  input  logic                iTick,
  input  logic                iRdReq,
  input  logic [ADDR_W-1:0]   iRdIdx,
  output logic                oRdValid,
  output logic [STATE_W-1:0]  oRdData,
  output logic [TS_W-1:0]     oRdTs,
  output logic                oRdErr,
  output logic [CNT_BITS-1:0] oCount,
  output logic                oOverflow,
  output logic                oWrPulse
);

`ifdef STATE_HIST_TS_EN
  localparam int ENTRY_W = STATE_W + TS_W;
`else
  localparam int ENTRY_W = STATE_W;
`endif

  logic [ADDR_W-1:0]   wr_ptr_reg;
  logic [STATE_W-1:0]  last_state_reg;
  logic                armed_reg;
  logic [CNT_BITS-1:0] count_reg;
  logic                overflow_reg;
  logic                wr_pulse_reg;
  rd_state_t           rd_state_reg;
  logic [ADDR_W-1:0]   rd_addr_reg;
  logic                rd_err_reg;
  logic                rd_valid_reg;
  logic                wr_en;
  logic                rd_en;
  logic [ENTRY_W-1:0]  wr_entry;
  logic [ENTRY_W-1:0]  rd_entry;

  // Clear wins over a write in the same cycle.
  assign wr_en = (armed_reg | (iCurState != last_state_reg)) & ~iFreeze & ~iClear;
  assign rd_en = (rd_state_reg == RD_LOOK);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wr_ptr_reg     <= '0;
      last_state_reg <= '0;
      armed_reg      <= 1'b1;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
      wr_pulse_reg   <= 1'b0;
    end else if (iClear) begin
      wr_ptr_reg     <= '0;
      last_state_reg <= '0;
      armed_reg      <= 1'b1;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
      wr_pulse_reg   <= 1'b0;
    end else begin
      // Tracks the input even while frozen, so changes during freeze are dropped.
      last_state_reg <= iCurState;
      wr_pulse_reg   <= wr_en;
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
        armed_reg  <= 1'b0;
        if (count_reg == CNT_BITS'(DEPTH)) begin
          overflow_reg <= 1'b1;
        end else begin
          count_reg <= count_reg + CNT_BITS'(1);
        end
      end
    end
  end

`ifdef STATE_HIST_TS_EN
  logic [TS_W-1:0] ts_cnt_reg;
  logic [TS_W-1:0] ts_store;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      ts_cnt_reg <= '0;
    end else if (iClear || wr_en) begin
      ts_cnt_reg <= '0;
    end else if (iTick && (ts_cnt_reg != '1)) begin
      ts_cnt_reg <= ts_cnt_reg + TS_W'(1);
    end
  end

  // The initial entry has no predecessor, so it carries no dwell time.
  assign ts_store = armed_reg ? '0 : ts_cnt_reg;
  assign wr_entry = {iCurState, ts_store};
  assign oRdData  = (rd_valid_reg && !rd_err_reg) ? rd_entry[ENTRY_W-1 -: STATE_W] : '0;
  assign oRdTs    = (rd_valid_reg && !rd_err_reg) ? rd_entry[TS_W-1:0] : '0;
`else
  logic unused_tick;

  assign unused_tick = iTick;
  assign wr_entry    = iCurState;
  assign oRdData     = (rd_valid_reg && !rd_err_reg) ? rd_entry : '0;
  assign oRdTs       = '0;
`endif

  state_hist_ram #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .iClk    (iClk),
    .iWrEn   (wr_en),
    .iWrAddr (wr_ptr_reg),
    .iWrData (wr_entry),
    .iRdEn   (rd_en),
    .iRdAddr (rd_addr_reg),
    .oRdData (rd_entry)
  );

  // Address is frozen at request time; later writes do not shift the age index.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      rd_state_reg <= RD_IDLE;
      rd_addr_reg  <= '0;
      rd_err_reg   <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      case (rd_state_reg)
        RD_IDLE: begin
          rd_valid_reg <= 1'b0;
          if (iRdReq) begin
            rd_addr_reg  <= wr_ptr_reg - ADDR_W'(1) - iRdIdx;
            rd_err_reg   <= ({1'b0, iRdIdx} >= count_reg);
            rd_state_reg <= RD_LOOK;
          end
        end
        RD_LOOK: begin
          rd_valid_reg <= 1'b1;
          rd_state_reg <= RD_DONE;
        end
        RD_DONE: begin
          rd_valid_reg <= 1'b0;
          rd_state_reg <= RD_IDLE;
        end
        default: begin
          rd_valid_reg <= 1'b0;
          rd_state_reg <= RD_IDLE;
        end
      endcase
    end
  end

  assign oRdValid  = rd_valid_reg;
  assign oRdErr    = rd_valid_reg & rd_err_reg;
  assign oCount    = count_reg;
  assign oOverflow = overflow_reg;
  assign oWrPulse  = wr_pulse_reg;

endmodule

// File: tb/tb_state_history_buffer.sv
// Randomized and directed bench for state_history_buffer against a queue-based
// model of the logged history (newest at the front).
`timescale 1ns/1ps
module tb_state_history_buffer;
  import state_hist_pkg::*;

  localparam int DEPTH  = DEPTH_D;
  localparam int TS_MAX = (1 << TS_W_D) - 1;
`ifdef STATE_HIST_TS_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic             iClk = 1'b0;
  logic             iRst;
  logic             iClear;
  logic [7:0]       iCurState;
  logic             iFreeze;
  logic             iTick;
  logic             iRdReq;
  logic [AW-1:0]    iRdIdx;
  logic             oRdValid;
  logic [7:0]       oRdData;
  logic [15:0]      oRdTs;
  logic             oRdErr;
  logic [CNT_W-1:0] oCount;
  logic             oOverflow;
  logic             oWrPulse;

  state_history_buffer dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iClear    (iClear),
    .iCurState (iCurState),
    .iFreeze   (iFreeze),
    .iTick     (iTick),
    .iRdReq    (iRdReq),
    .iRdIdx    (iRdIdx),
    .oRdValid  (oRdValid),
    .oRdData   (oRdData),
    .oRdTs     (oRdTs),
    .oRdErr    (oRdErr),
    .oCount    (oCount),
    .oOverflow (oOverflow),
    .oWrPulse  (oWrPulse)
  );

  always #5 iClk = ~iClk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  // Reference model: history as a queue, plus change-detect and dwell state.
  entry_t     hist[$];
  logic [7:0] m_last;
  bit         m_armed;
  bit         m_ovf;
  bit         m_pulse;
  int         m_ts;

  task automatic model_reset();
    hist.delete();
    m_last  = 8'h00;
    m_armed = 1'b1;
    m_ovf   = 1'b0;
    m_pulse = 1'b0;
    m_ts    = 0;
  endtask

  task automatic cycle();
    entry_t e;
    bit     wr;
    @(posedge iClk);
    if (iClear) begin
      model_reset();
    end else begin
      wr      = (m_armed || (iCurState != m_last)) && !iFreeze;
      m_pulse = wr;
      if (wr) begin
        e.state = iCurState;
        e.ts    = m_armed ? 16'd0 : 16'(m_ts);
        if (hist.size() == DEPTH) begin
          m_ovf = 1'b1;
          void'(hist.pop_back());
        end
        hist.push_front(e);
        m_ts    = 0;
        m_armed = 1'b0;
      end else if (iTick && m_ts < TS_MAX) begin
        m_ts++;
      end
      m_last = iCurState;
    end
    #1;
  endtask

  task automatic do_read(input int idx, input bit chg, input logic [7:0] look_state,
                         output logic [1:0] vseq, output logic [7:0] d, output logic err,
                         output logic [15:0] ts, output logic [7:0] exp_d,
                         output logic exp_err, output logic [15:0] exp_ts);
    exp_err = (idx >= hist.size());
    exp_d   = exp_err ? 8'h00 : hist[idx].state;
    exp_ts  = (exp_err || !TS_EN) ? 16'h0000 : hist[idx].ts;
    iRdReq  = 1'b1;
    iRdIdx  = AW'(idx);
    cycle();
    iRdReq  = 1'b0;
    vseq[1] = oRdValid;
    if (chg) iCurState = look_state;
    cycle();
    vseq[0] = oRdValid;
    d       = oRdData;
    err     = oRdErr;
    ts      = oRdTs;
    cycle();
    $display("read idx=%0d data=%h err=%b ts=%0d", idx, d, err, ts);
  endtask

  task automatic test_reset();
    logic [1:0]  vs;
    logic [7:0]  d, ed;
    logic        er, ee;
    logic [15:0] ts, et;
    iRst = 1'b1; iClear = 1'b0; iCurState = 8'h00; iFreeze = 1'b0;
    iTick = 1'b0; iRdReq = 1'b0; iRdIdx = '0;
    repeat (3) @(posedge iClk);
    #1;
    checks++;
    if ({oRdValid, oRdData, oRdTs, oRdErr, oCount, oOverflow, oWrPulse} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b data=%h ts=%h err=%b count=%0d ovf=%b pulse=%b want all 0",
               oRdValid, oRdData, oRdTs, oRdErr, oCount, oOverflow, oWrPulse);
    end
    iCurState = 8'h10;
    iRst = 1'b0;
    model_reset();
    cycle();
    checks++;
    if ({oWrPulse, oOverflow, oCount} !== {m_pulse, m_ovf, CNT_W'(hist.size())}) begin
      errors++;
      $display("FAIL first_write got pulse=%b ovf=%b count=%0d want pulse=%b ovf=%b count=%0d",
               oWrPulse, oOverflow, oCount, m_pulse, m_ovf, hist.size());
    end
    cycle();
    checks++;
    if (oWrPulse !== m_pulse) begin
      errors++;
      $display("FAIL pulse_one_cycle got=%b want=%b", oWrPulse, m_pulse);
    end
    do_read(0, 1'b0, 8'h00, vs, d, er, ts, ed, ee, et);
    checks++;
    if (vs !== 2'b01) begin
      errors++;
      $display("FAIL first_read_latency got=%b want=01", vs);
    end
    checks++;
    if (d !== ed || er !== ee) begin
      errors++;
      $display("FAIL first_read_data got data=%h err=%b want data=%h err=%b", d, er, ed, ee);
    end
  endtask

  task automatic test_sequence();
    logic [1:0]  vs;
    logic [7:0]  d, ed;
    logic        er, ee;
    logic [15:0] ts, et;
    iClear = 1'b1; iCurState = 8'h10;
    cycle();
    iClear = 1'b0;
    checks++;
    if (oCount !== CNT_W'(hist.size())) begin
      errors++;
      $display("FAIL clear_count got=%0d want=%0d", oCount, hist.size());
    end
    for (int s = 0; s < 3; s++) begin
      iCurState = 8'h10 + 8'(s);
      cycle();
    end
    for (int idx = 0; idx < 4; idx++) begin
      do_read(idx, 1'b0, 8'h00, vs, d, er, ts, ed, ee, et);
      checks++;
      if (vs !== 2'b01 || d !== ed || er !== ee || (!ee && ts !== et)) begin
        errors++;
        $display("FAIL seq_read idx=%0d got vseq=%b data=%h err=%b ts=%0d want vseq=01 data=%h err=%b ts=%0d",
                 idx, vs, d, er, ts, ed, ee, et);
      end
    end
  endtask

  task automatic test_overflow();
    logic [1:0]  vs;
    logic [7:0]  d, ed;
    logic        er, ee;
    logic [15:0] ts, et;
    int          idxs[2] = '{0, 15};
    iClear = 1'b1;
    cycle();
    iClear = 1'b0;
    for (int i = 0; i < 20; i++) begin
      iCurState = 8'h30 + 8'(i);
      cycle();
      if (i == 15) begin
        checks++;
        if ({oOverflow, oCount} !== {m_ovf, CNT_W'(hist.size())}) begin
          errors++;
          $display("FAIL full_no_overflow got ovf=%b count=%0d want ovf=%b count=%0d",
                   oOverflow, oCount, m_ovf, hist.size());
        end
      end
    end
    checks++;
    if ({oOverflow, oCount} !== {m_ovf, CNT_W'(hist.size())}) begin
      errors++;
      $display("FAIL overflow_state got ovf=%b count=%0d want ovf=%b count=%0d",
               oOverflow, oCount, m_ovf, hist.size());
    end
    foreach (idxs[k]) begin
      do_read(idxs[k], 1'b0, 8'h00, vs, d, er, ts, ed, ee, et);
      checks++;
      if (vs !== 2'b01 || d !== ed || er !== ee || (!ee && ts !== et)) begin
        errors++;
        $display("FAIL wrap_read idx=%0d got vseq=%b data=%h err=%b want vseq=01 data=%h err=%b",
                 idxs[k], vs, d, er, ed, ee);
      end
    end
  endtask

  task automatic test_freeze_clear();
    logic [1:0]  vs;
    logic [7:0]  d, ed;
    logic        er, ee;
    logic [15:0] ts, et;
    iCurState = 8'h20;
    cycle();
    iFreeze = 1'b1;
    for (int s = 1; s < 3; s++) begin
      iCurState = 8'h20 + 8'(s);
      cycle();
      checks++;
      if ({oWrPulse, oCount} !== {m_pulse, CNT_W'(hist.size())}) begin
        errors++;
        $display("FAIL frozen_write got pulse=%b count=%0d want pulse=%b count=%0d",
                 oWrPulse, oCount, m_pulse, hist.size());
      end
    end
    iFreeze = 1'b0;
    cycle();
    checks++;
    if ({oWrPulse, oCount} !== {m_pulse, CNT_W'(hist.size())}) begin
      errors++;
      $display("FAIL unfreeze_same got pulse=%b count=%0d want pulse=%b count=%0d",
               oWrPulse, oCount, m_pulse, hist.size());
    end
    iClear = 1'b1;
    cycle();
    iClear = 1'b0;
    checks++;
    if ({oWrPulse, oOverflow, oCount} !== {m_pulse, m_ovf, CNT_W'(hist.size())}) begin
      errors++;
      $display("FAIL clear_state got pulse=%b ovf=%b count=%0d want pulse=%b ovf=%b count=%0d",
               oWrPulse, oOverflow, oCount, m_pulse, m_ovf, hist.size());
    end
    cycle();
    checks++;
    if ({oWrPulse, oCount} !== {m_pulse, CNT_W'(hist.size())}) begin
      errors++;
      $display("FAIL relog_after_clear got pulse=%b count=%0d want pulse=%b count=%0d",
               oWrPulse, oCount, m_pulse, hist.size());
    end
    do_read(0, 1'b0, 8'h00, vs, d, er, ts, ed, ee, et);
    checks++;
    if (vs !== 2'b01 || d !== ed || er !== ee) begin
      errors++;
      $display("FAIL relog_read got vseq=%b data=%h err=%b want vseq=01 data=%h err=%b",
               vs, d, er, ed, ee);
    end
    iClear = 1'b1; iCurState = 8'h23;
    cycle();
    iClear = 1'b0;
    checks++;
    if ({oWrPulse, oCount} !== {m_pulse, CNT_W'(hist.size())}) begin
      errors++;
      $display("FAIL clear_beats_write got pulse=%b count=%0d want pulse=%b count=%0d",
               oWrPulse, oCount, m_pulse, hist.size());
    end
    cycle();
  endtask

`ifdef STATE_HIST_TS_EN
  task automatic test_timestamp();
    logic [1:0]  vs;
    logic [7:0]  d, ed;
    logic        er, ee;
    logic [15:0] ts, et;
    iClear = 1'b1; iCurState = 8'hA0;
    cycle();
    iClear = 1'b0;
    cycle();
    iTick = 1'b1;
    repeat (5) cycle();
    iTick = 1'b0; iCurState = 8'hB0;
    cycle();
    for (int idx = 0; idx < 2; idx++) begin
      do_read(idx, 1'b0, 8'h00, vs, d, er, ts, ed, ee, et);
      checks++;
      if (vs !== 2'b01 || d !== ed || er !== ee || ts !== et) begin
        errors++;
        $display("FAIL dwell_read idx=%0d got data=%h ts=%0d want data=%h ts=%0d", idx, d, ts, ed, et);
      end
    end
    iTick = 1'b1; iCurState = 8'hC0;
    cycle();
    iTick = 1'b0; iCurState = 8'hC1;
    cycle();
    do_read(0, 1'b0, 8'h00, vs, d, er, ts, ed, ee, et);
    checks++;
    if (d !== ed || ts !== et) begin
      errors++;
      $display("FAIL tick_on_write got data=%h ts=%0d want data=%h ts=%0d", d, ts, ed, et);
    end
    iCurState = 8'hD0;
    cycle();
    iTick = 1'b1;
    repeat (65540) cycle();
    iTick = 1'b0; iCurState = 8'hD1;
    cycle();
    do_read(0, 1'b0, 8'h00, vs, d, er, ts, ed, ee, et);
    checks++;
    if (d !== ed || ts !== et) begin
      errors++;
      $display("FAIL ts_saturate got data=%h ts=%h want data=%h ts=%h", d, ts, ed, et);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [8:0] mask;
    int         bad;
    bad    = 0;
    iRdIdx = '0;
    iRdReq = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cycle();
      mask[k] = oRdValid;
      if (oRdValid === 1'b1 && oRdData !== hist[0].state) bad++;
    end
    iRdReq = 1'b0;
    cycle();
    $display("read back_to_back valid_mask=%b", mask);
    checks++;
    if (mask !== 9'b010010010) begin
      errors++;
      $display("FAIL b2b_valid_mask got=%b want=010010010", mask);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_data got %0d wrong pulses want 0", bad);
    end
  endtask

  task automatic test_random();
    logic [1:0]  vs;
    logic [7:0]  d, ed;
    logic        er, ee;
    logic [15:0] ts, et;
    int          idx;
    for (int it = 0; it < 60; it++) begin
      iCurState = 8'h50 + 8'($urandom_range(0, 5));
      iFreeze   = ($urandom_range(0, 3) == 0);
      iTick     = 1'($urandom_range(0, 1));
      cycle();
      checks++;
      if ({oWrPulse, oOverflow, oCount} !== {m_pulse, m_ovf, CNT_W'(hist.size())}) begin
        errors++;
        $display("FAIL rand_status it=%0d got pulse=%b ovf=%b count=%0d want pulse=%b ovf=%b count=%0d",
                 it, oWrPulse, oOverflow, oCount, m_pulse, m_ovf, hist.size());
      end
      if (it % 5 == 4) begin
        idx = $urandom_range(0, DEPTH - 1);
        do_read(idx, 1'b1, 8'h50 + 8'($urandom_range(0, 5)), vs, d, er, ts, ed, ee, et);
        checks++;
        if (vs !== 2'b01 || d !== ed || er !== ee || (!ee && ts !== et)) begin
          errors++;
          $display("FAIL rand_read idx=%0d got vseq=%b data=%h err=%b ts=%0d want vseq=01 data=%h err=%b ts=%0d",
                   idx, vs, d, er, ts, ed, ee, et);
        end
      end
    end
    iFreeze = 1'b0;
    iTick   = 1'b0;
  endtask

  task automatic test_reset_in_look();
    bit saw;
    saw    = 1'b0;
    iRdIdx = '0;
    iRdReq = 1'b1;
    cycle();
    iRdReq = 1'b0;
    #2;
    iRst = 1'b1;
    #1;
    checks++;
    if ({oRdValid, oRdData, oRdTs, oRdErr, oCount, oOverflow, oWrPulse} !== '0) begin
      errors++;
      $display("FAIL reset_in_look_outputs got valid=%b data=%h err=%b count=%0d ovf=%b pulse=%b want all 0",
               oRdValid, oRdData, oRdErr, oCount, oOverflow, oWrPulse);
    end
    repeat (3) begin
      @(posedge iClk);
      #1;
      if (oRdValid !== 1'b0) saw = 1'b1;
    end
    checks++;
    if (saw) begin
      errors++;
      $display("FAIL reset_kills_read got a valid pulse want none");
    end
    iCurState = 8'h77;
    iRst = 1'b0;
    model_reset();
    cycle();
    checks++;
    if ({oWrPulse, oCount} !== {m_pulse, CNT_W'(hist.size())}) begin
      errors++;
      $display("FAIL post_reset_log got pulse=%b count=%0d want pulse=%b count=%0d",
               oWrPulse, oCount, m_pulse, hist.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_overflow();
    test_freeze_clear();
`ifdef STATE_HIST_TS_EN
    test_timestamp();
`endif
    test_back_to_back();
    test_random();
    test_reset_in_look();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
